// File: rtl/dc_biu_burst_ctrl.sv
// dc_biu_burst_ctrl: data-cache bus interface stage.
// Turns the cache FSM's read/write/burst requests into Wishbone B3 classic
// single cycles or 4-beat wrap bursts, returning per-beat valid/error pulses
// and registered read data.
// Optional feature macro: DC_BIU_TIMEOUT_EN (no-response watchdog that
// terminates the cycle like a bus error after TIMEOUT_CYC silent cycles).
module dc_biu_burst_ctrl #(
   parameter int unsigned AW          = 32,
   parameter int unsigned DW          = 32,
   parameter int unsigned BURST_LEN   = 4,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          biu_read,
   input  logic          biu_write,
   input  logic          burst,
   input  logic [AW-1:0] biu_addr,
   input  logic [3:0]    biu_sel,
   input  logic [DW-1:0] biu_dat_i,
   output logic [DW-1:0] biu_dat_o,
   output logic          biudata_valid,
   output logic          biudata_error,
   output logic          biu_busy,
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   output logic          wb_we_o,
   output logic [3:0]    wb_sel_o,
   output logic [AW-1:0] wb_adr_o,
   output logic [2:0]    wb_cti_o,
   output logic [1:0]    wb_bte_o,
   output logic [DW-1:0] wb_dat_o,
   input  logic [DW-1:0] wb_dat_i,
   input  logic          wb_ack_i,
   input  logic          wb_err_i,
   input  logic          wb_rty_i
);

   localparam int unsigned CNT_W = 2;
   localparam int unsigned WD_W  = 8;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;

   // Elaboration-time parameter sanity: the wrap logic only covers 4-beat lines.
   if (BURST_LEN != 4) begin : g_bad_burst_len
      $error("dc_biu_burst_ctrl: BURST_LEN must be 4");
   end
   if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 255) begin : g_bad_timeout
      $error("dc_biu_burst_ctrl: TIMEOUT_CYC must be 1..255");
   end
   if (AW < 5) begin : g_bad_aw
      $error("dc_biu_burst_ctrl: AW must be at least 5");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_RETRY
   } state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    adr_q, adr_d;
   logic             we_q, we_d;
   logic             burst_q, burst_d;
   logic             cyc_q, cyc_d;
   logic             stb_q, stb_d;
   logic [3:0]       sel_q, sel_d;
   logic [2:0]       cti_q, cti_d;
   logic [1:0]       bte_q, bte_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    dat_q, dat_d;
   logic             valid_q, valid_d;
   logic             error_q, error_d;
   logic             busy_q, busy_d;

   logic             drop_c;
   logic             last_beat_c;
   logic             bus_err_c;

   assign last_beat_c = !burst_q || (cnt_q == CNT_W'(BURST_LEN - 1));

`ifdef DC_BIU_TIMEOUT_EN
   logic [WD_W-1:0]  wdog_q, wdog_d;
   logic             timeout_c;

   // A silent ACTIVE cycle that completes the count is treated as a bus error.
   assign timeout_c = (state_q == ST_ACTIVE) && !wb_ack_i && !wb_err_i && !wb_rty_i &&
                      (wdog_q == WD_W'(TIMEOUT_CYC - 1));
   assign bus_err_c = wb_err_i || timeout_c;

   // Watchdog: counts silent ACTIVE cycles, cleared by any slave response or outside ACTIVE.
   always_comb begin
      wdog_d = '0;
      if (state_q == ST_ACTIVE && !wb_ack_i && !wb_err_i && !wb_rty_i) begin
         wdog_d = wdog_q + WD_W'(1);
      end
   end

   // Watchdog register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   assign bus_err_c = wb_err_i;
`endif

   // Next-state and registered-output logic; err outranks ack, ack outranks rty.
   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      we_d    = we_q;
      burst_d = burst_q;
      cyc_d   = cyc_q;
      stb_d   = stb_q;
      sel_d   = sel_q;
      cti_d   = cti_q;
      bte_d   = bte_q;
      cnt_d   = cnt_q;
      dat_d   = dat_q;
      valid_d = 1'b0;
      error_d = 1'b0;
      busy_d  = busy_q;
      drop_c  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (biu_write || biu_read) begin
               state_d = ST_ACTIVE;
               we_d    = biu_write;
               burst_d = burst;
               cnt_d   = '0;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               busy_d  = 1'b1;
               if (burst) begin
                  adr_d = {biu_addr[AW-1:2], 2'b00};
                  sel_d = 4'hF;
                  cti_d = CTI_INCR;
                  bte_d = BTE_WRAP4;
               end else begin
                  adr_d = biu_addr;
                  sel_d = biu_sel;
                  cti_d = CTI_CLASSIC;
                  bte_d = BTE_LINEAR;
               end
            end
         end

         ST_ACTIVE: begin
            if (bus_err_c) begin
               error_d = 1'b1;
               drop_c  = 1'b1;
            end else if (wb_ack_i) begin
               valid_d = 1'b1;
               dat_d   = wb_dat_i;
               if (last_beat_c) begin
                  drop_c = 1'b1;
               end else begin
                  cnt_d      = cnt_q + CNT_W'(1);
                  adr_d[3:2] = adr_q[3:2] + 2'd1;
                  if (cnt_q == CNT_W'(BURST_LEN - 2)) begin
                     cti_d = CTI_EOB;
                  end
               end
            end else if (wb_rty_i) begin
               state_d = ST_RETRY;
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
            end
         end

         ST_RETRY: begin
            state_d = ST_ACTIVE;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
            drop_c  = 1'b1;
         end
      endcase

      if (drop_c) begin
         state_d = ST_IDLE;
         cyc_d   = 1'b0;
         stb_d   = 1'b0;
         we_d    = 1'b0;
         sel_d   = 4'h0;
         cti_d   = CTI_CLASSIC;
         bte_d   = BTE_LINEAR;
         busy_d  = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         adr_q   <= '0;
         we_q    <= 1'b0;
         burst_q <= 1'b0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         sel_q   <= 4'h0;
         cti_q   <= CTI_CLASSIC;
         bte_q   <= BTE_LINEAR;
         cnt_q   <= '0;
         dat_q   <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         we_q    <= we_d;
         burst_q <= burst_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
         sel_q   <= sel_d;
         cti_q   <= cti_d;
         bte_q   <= bte_d;
         cnt_q   <= cnt_d;
         dat_q   <= dat_d;
         valid_q <= valid_d;
         error_q <= error_d;
         busy_q  <= busy_d;
      end
   end

   assign biu_dat_o     = dat_q;
   assign biudata_valid = valid_q;
   assign biudata_error = error_q;
   assign biu_busy      = busy_q;
   assign wb_cyc_o      = cyc_q;
   assign wb_stb_o      = stb_q;
   assign wb_we_o       = we_q;
   assign wb_sel_o      = sel_q;
   assign wb_adr_o      = adr_q;
   assign wb_cti_o      = cti_q;
   assign wb_bte_o      = bte_q;

   // Upstream already presents the beat's write data for the current wb_adr_o.
   assign wb_dat_o      = biu_dat_i;

endmodule

// File: tb/tb_dc_biu_burst_ctrl.sv
// Self-checking bench for dc_biu_burst_ctrl: a scripted/random Wishbone slave
// plus a line-wrap address/response model derived from the bus rules.
`timescale 1ns/1ps
module tb_dc_biu_burst_ctrl;

   logic        clk, rst;
   logic        biu_read, biu_write, burst;
   logic [31:0] biu_addr, biu_dat_i, biu_dat_o;
   logic [3:0]  biu_sel;
   logic        biudata_valid, biudata_error, biu_busy;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [2:0]  wb_cti_o;
   logic [1:0]  wb_bte_o;
   logic        wb_ack_i, wb_err_i, wb_rty_i;

   int checks, errors;

   dc_biu_burst_ctrl #(.AW(32), .DW(32), .BURST_LEN(4), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst(rst),
      .biu_read(biu_read), .biu_write(biu_write), .burst(burst),
      .biu_addr(biu_addr), .biu_sel(biu_sel), .biu_dat_i(biu_dat_i),
      .biu_dat_o(biu_dat_o), .biudata_valid(biudata_valid),
      .biudata_error(biudata_error), .biu_busy(biu_busy),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_cti_o(wb_cti_o),
      .wb_bte_o(wb_bte_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observations recorded by the slave at each response it gives (0 ack, 1 err, 2 rty).
   int          ob_kind[$];
   logic [31:0] ob_adr[$];
   logic [2:0]  ob_cti[$];
   logic [1:0]  ob_bte[$];
   logic [3:0]  ob_sel[$];
   logic        ob_we[$];
   logic [31:0] ob_wdo[$];
   logic [31:0] ob_wdi[$];
   logic [31:0] ob_rdat[$];
   logic [31:0] ack_dat[$];
   int          ob_err_n, ob_cyc_n, ob_gap_n;
   logic        ob_vbusy, ob_cyc_end;
   bit          ob_done;

   // Model of a wrap-4 line burst: word index advances modulo 4 inside the 16-byte line.
   function automatic logic [31:0] exp_adr(input logic [31:0] a, input bit b, input int k);
      logic [31:0] w;
      if (!b) return a;
      w = ((a >> 2) + 32'(k)) % 32'd4;
      return (a & 32'hFFFF_FFF0) | (w << 2);
   endfunction

   // Issue one request and play the slave until the controller goes idle or the window expires.
   task automatic run_xfer(input bit we, input bit brst, input logic [31:0] addr,
                           input logic [3:0] sel, input int err_at, input int rty_at,
                           input int wmin, input int wmax, input bit noise, input bit silent,
                           input int window, input bit fix_wdat, input logic [31:0] wdat);
      int beat, wait_left, kind;
      bit retried;
      ob_kind.delete(); ob_adr.delete(); ob_cti.delete(); ob_bte.delete();
      ob_sel.delete(); ob_we.delete(); ob_wdo.delete(); ob_wdi.delete();
      ob_rdat.delete(); ack_dat.delete();
      ob_err_n = 0; ob_cyc_n = 0; ob_gap_n = 0;
      ob_vbusy = 1'b1; ob_cyc_end = 1'b1; ob_done = 0;
      beat = 0; retried = 0;
      @(negedge clk);
      biu_write = we; biu_read = !we; burst = brst; biu_addr = addr; biu_sel = sel;
      @(negedge clk);
      biu_write = 1'b0; biu_read = 1'b0; burst = 1'($urandom);
      biu_addr = $urandom; biu_sel = 4'($urandom);
      wait_left = int'($urandom_range(wmax, wmin));
      for (int c = 0; c < window && !ob_done; c++) begin
         wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = $urandom;
         biu_dat_i = fix_wdat ? wdat : $urandom;
         #1;
         if (biudata_valid) begin
            ob_rdat.push_back(biu_dat_o);
            ob_vbusy = biu_busy;
         end
         if (biudata_error) ob_err_n++;
         if (wb_cyc_o) ob_cyc_n++;
         if (biu_busy && !wb_stb_o) ob_gap_n++;
         if (!biu_busy) begin
            ob_done = 1;
            ob_cyc_end = wb_cyc_o;
         end else if (wb_cyc_o && wb_stb_o && !silent) begin
            if (wait_left > 0) begin
               wait_left--;
            end else begin
               kind = (beat == err_at) ? 1 : ((beat == rty_at && !retried) ? 2 : 0);
               ob_kind.push_back(kind); ob_adr.push_back(wb_adr_o); ob_cti.push_back(wb_cti_o);
               ob_bte.push_back(wb_bte_o); ob_sel.push_back(wb_sel_o); ob_we.push_back(wb_we_o);
               ob_wdo.push_back(wb_dat_o); ob_wdi.push_back(biu_dat_i);
               if (kind == 1) begin
                  wb_err_i = 1'b1;
                  if (noise) begin wb_ack_i = 1'($urandom); wb_rty_i = 1'($urandom); end
               end else if (kind == 2) begin
                  wb_rty_i = 1'b1;
                  retried = 1;
               end else begin
                  wb_ack_i = 1'b1;
                  ack_dat.push_back(wb_dat_i);
                  beat++;
                  if (noise) wb_rty_i = 1'($urandom);
               end
               wait_left = int'($urandom_range(wmax, wmin));
            end
         end
         @(negedge clk);
      end
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      biu_read = 1'b0; biu_write = 1'b0; burst = 1'b0; biu_addr = '0; biu_sel = '0;
      biu_dat_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, biudata_valid, biudata_error, biu_busy} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctl got %b exp 000000",
                  {wb_cyc_o, wb_stb_o, wb_we_o, biudata_valid, biudata_error, biu_busy});
      end
      checks++;
      if ({wb_cti_o, wb_bte_o, wb_sel_o} !== 9'b0) begin
         errors++;
         $display("FAIL reset_cti_bte_sel got %b exp 000000000", {wb_cti_o, wb_bte_o, wb_sel_o});
      end
      checks++;
      if ({wb_adr_o, biu_dat_o} !== 64'b0) begin
         errors++;
         $display("FAIL reset_adr_dat got %h exp 0", {wb_adr_o, biu_dat_o});
      end
   endtask

   task automatic test_burst_read;
      logic [31:0] ea [4];
      logic [2:0]  ec [4];
      ea[0] = 32'h1008; ea[1] = 32'h100C; ea[2] = 32'h1000; ea[3] = 32'h1004;
      ec[0] = 3'b010;   ec[1] = 3'b010;   ec[2] = 3'b010;   ec[3] = 3'b111;
      run_xfer(1'b0, 1'b1, 32'h0000_1008, 4'h0, -1, -1, 0, 0, 1'b0, 1'b0, 40, 1'b0, '0);
      checks++;
      if (ob_kind.size() != 4 || ob_rdat.size() != 4) begin
         errors++;
         $display("FAIL burst_beats got %0d acks %0d valids exp 4 4", ob_kind.size(), ob_rdat.size());
      end
      for (int i = 0; i < 4 && i < ob_adr.size(); i++) begin
         checks++;
         if ({ob_adr[i], ob_cti[i], ob_bte[i], ob_sel[i], ob_we[i]} !== {ea[i], ec[i], 2'b01, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL burst_beat%0d got adr %h cti %b bte %b sel %h we %b exp adr %h cti %b bte 01 sel f we 0",
                     i, ob_adr[i], ob_cti[i], ob_bte[i], ob_sel[i], ob_we[i], ea[i], ec[i]);
         end
      end
      for (int i = 0; i < ob_rdat.size() && i < ack_dat.size(); i++) begin
         checks++;
         if (ob_rdat[i] !== ack_dat[i]) begin
            errors++;
            $display("FAIL burst_rdata%0d got %h exp %h", i, ob_rdat[i], ack_dat[i]);
         end
      end
      checks++;
      if (ob_vbusy !== 1'b0 || !ob_done) begin
         errors++;
         $display("FAIL burst_busy_end got busy %b done %0d exp busy 0 done 1", ob_vbusy, ob_done);
      end
   endtask

   task automatic test_single_write;
      run_xfer(1'b1, 1'b0, 32'h0000_2002, 4'b0011, -1, -1, 3, 3, 1'b0, 1'b0, 40, 1'b1, 32'hDEADBEEF);
      checks++;
      if (ob_cyc_n != 4) begin
         errors++;
         $display("FAIL single_wr_cyc_len got %0d exp 4", ob_cyc_n);
      end
      checks++;
      if (ob_adr.size() != 1 || ob_rdat.size() != 1) begin
         errors++;
         $display("FAIL single_wr_count got %0d beats %0d valids exp 1 1", ob_adr.size(), ob_rdat.size());
      end else begin
         checks++;
         if ({ob_adr[0], ob_cti[0], ob_bte[0], ob_sel[0], ob_we[0], ob_wdo[0]} !==
             {32'h2002, 3'b000, 2'b00, 4'b0011, 1'b1, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL single_wr_beat got adr %h cti %b bte %b sel %b we %b dat %h exp 2002 000 00 0011 1 deadbeef",
                     ob_adr[0], ob_cti[0], ob_bte[0], ob_sel[0], ob_we[0], ob_wdo[0]);
         end
      end
   endtask

   task automatic test_burst_err;
      run_xfer(1'b0, 1'b1, $urandom, 4'h0, 2, -1, 0, 1, 1'b0, 1'b0, 40, 1'b0, '0);
      checks++;
      if (ob_rdat.size() != 2 || ob_err_n != 1 || ob_kind.size() != 3) begin
         errors++;
         $display("FAIL burst_err got valids %0d errs %0d beats %0d exp 2 1 3",
                  ob_rdat.size(), ob_err_n, ob_kind.size());
      end
      checks++;
      if (ob_cyc_end !== 1'b0 || !ob_done) begin
         errors++;
         $display("FAIL burst_err_cyc got cyc %b done %0d exp 0 1", ob_cyc_end, ob_done);
      end
   endtask

   task automatic test_retry;
      logic [31:0] a;
      a = $urandom;
      run_xfer(1'b0, 1'b0, a, 4'b1100, -1, 0, 0, 0, 1'b0, 1'b0, 40, 1'b0, '0);
      checks++;
      if (ob_kind.size() != 2 || ob_gap_n != 1 || ob_rdat.size() != 1) begin
         errors++;
         $display("FAIL retry_shape got attempts %0d gap %0d valids %0d exp 2 1 1",
                  ob_kind.size(), ob_gap_n, ob_rdat.size());
      end else begin
         checks++;
         if (ob_adr[0] !== a || ob_adr[1] !== a) begin
            errors++;
            $display("FAIL retry_adr got %h %h exp %h", ob_adr[0], ob_adr[1], a);
         end
      end
   endtask

   task automatic test_reset_mid_burst;
      logic [31:0] a;
      a = $urandom;
      @(negedge clk);
      biu_read = 1'b1; burst = 1'b1; biu_addr = a;
      @(negedge clk);
      biu_read = 1'b0; burst = 1'b0;
      wb_ack_i = 1'b1; wb_dat_i = $urandom;
      @(negedge clk);
      checks++;
      if (biudata_valid !== 1'b1 || wb_cyc_o !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_beat1 got valid %b cyc %b exp 1 1", biudata_valid, wb_cyc_o);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({wb_cyc_o, wb_stb_o, biudata_valid, biu_busy} !== 4'b0) begin
         errors++;
         $display("FAIL rst_mid_async got %b exp 0000", {wb_cyc_o, wb_stb_o, biudata_valid, biu_busy});
      end
      wb_ack_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      a = $urandom;
      run_xfer(1'b0, 1'b1, a, 4'h0, -1, -1, 0, 0, 1'b0, 1'b0, 40, 1'b0, '0);
      checks++;
      if (ob_adr.size() != 4 || ob_adr[0] !== exp_adr(a, 1'b1, 0) || ob_cti[0] !== 3'b010) begin
         errors++;
         $display("FAIL rst_mid_fresh got beats %0d first %h exp 4 %h",
                  ob_adr.size(), (ob_adr.size() > 0) ? ob_adr[0] : 32'hx, exp_adr(a, 1'b1, 0));
      end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      biu_read = 1'b1; burst = 1'b0; biu_addr = $urandom; biu_sel = 4'hF;
      @(negedge clk);
      wb_ack_i = 1'b1;
      @(negedge clk);
      wb_ack_i = 1'b0;
      checks++;
      if (biudata_valid !== 1'b1 || biu_busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first got valid %b busy %b exp 1 0", biudata_valid, biu_busy);
      end
      @(negedge clk);
      biu_read = 1'b0;
      checks++;
      if (biu_busy !== 1'b1 || wb_cyc_o !== 1'b1) begin
         errors++;
         $display("FAIL b2b_restart got busy %b cyc %b exp 1 1", biu_busy, wb_cyc_o);
      end
      wb_ack_i = 1'b1;
      @(negedge clk);
      wb_ack_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random;
      for (int t = 0; t < 24; t++) begin
         bit          we, brst;
         logic [31:0] addr;
         logic [3:0]  sel;
         int          n, err_at, rty_at, n_ack, n_err, n_rty;
         int          e_kind[$];
         int          e_beat[$];
         logic [2:0]  ecti;
         we = 1'($urandom); brst = 1'($urandom); addr = $urandom; sel = 4'($urandom);
         n = brst ? 4 : 1;
         err_at = ($urandom_range(3, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
         rty_at = ($urandom_range(2, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
         run_xfer(we, brst, addr, sel, err_at, rty_at, 0, 3, 1'b1, 1'b0, 100, 1'b0, '0);
         n_ack = 0; n_err = 0; n_rty = 0;
         for (int k = 0; k < n; k++) begin
            if (k == err_at) begin
               e_kind.push_back(1); e_beat.push_back(k); n_err++;
               break;
            end
            if (k == rty_at) begin
               e_kind.push_back(2); e_beat.push_back(k); n_rty++;
            end
            e_kind.push_back(0); e_beat.push_back(k); n_ack++;
         end
         checks++;
         if (!ob_done || ob_kind.size() != e_kind.size() || ob_rdat.size() != n_ack ||
             ob_err_n != n_err || ob_gap_n != n_rty || ob_cyc_end !== 1'b0) begin
            errors++;
            $display("FAIL rnd_shape t=%0d got done %0d resp %0d val %0d err %0d gap %0d exp 1 %0d %0d %0d %0d",
                     t, ob_done, ob_kind.size(), ob_rdat.size(), ob_err_n, ob_gap_n,
                     e_kind.size(), n_ack, n_err, n_rty);
         end
         for (int i = 0; i < ob_kind.size() && i < e_kind.size(); i++) begin
            ecti = brst ? ((e_beat[i] == n - 1) ? 3'b111 : 3'b010) : 3'b000;
            checks++;
            if ({ob_adr[i], ob_cti[i], ob_bte[i], ob_sel[i], ob_we[i]} !==
                {exp_adr(addr, brst, e_beat[i]), ecti, (brst ? 2'b01 : 2'b00), (brst ? 4'hF : sel), we} ||
                (we && ob_wdo[i] !== ob_wdi[i])) begin
               errors++;
               $display("FAIL rnd_beat t=%0d i=%0d got adr %h cti %b sel %h we %b exp adr %h cti %b sel %h we %b",
                        t, i, ob_adr[i], ob_cti[i], ob_sel[i], ob_we[i],
                        exp_adr(addr, brst, e_beat[i]), ecti, (brst ? 4'hF : sel), we);
            end
         end
         for (int i = 0; i < ob_rdat.size() && i < ack_dat.size(); i++) begin
            checks++;
            if (ob_rdat[i] !== ack_dat[i]) begin
               errors++;
               $display("FAIL rnd_rdata t=%0d i=%0d got %h exp %h", t, i, ob_rdat[i], ack_dat[i]);
            end
         end
      end
   endtask

   task automatic test_timeout;
      run_xfer(1'b0, 1'b0, $urandom, 4'hF, -1, -1, 0, 0, 1'b0, 1'b1, 50, 1'b0, '0);
`ifdef DC_BIU_TIMEOUT_EN
      checks++;
      if (ob_err_n != 1 || ob_cyc_n != 8 || !ob_done || ob_rdat.size() != 0) begin
         errors++;
         $display("FAIL timeout_err got errs %0d cyc %0d done %0d valids %0d exp 1 8 1 0",
                  ob_err_n, ob_cyc_n, ob_done, ob_rdat.size());
      end
`else
      checks++;
      if (ob_err_n != 0 || ob_cyc_n != 50) begin
         errors++;
         $display("FAIL no_timeout_wait got errs %0d cyc %0d exp 0 50", ob_err_n, ob_cyc_n);
      end
`endif
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_burst_read();
      test_single_write();
      test_burst_err();
      test_retry();
      test_reset_mid_burst();
      test_back_to_back();
      test_random();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit reached without finishing");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/dc_biu_burst_ctrl.md
Name: dc_biu_burst_ctrl

Overview:
- Bus-interface stage directly downstream of the data-cache FSM.
- Converts the FSM's biu_read/biu_write/burst requests into Wishbone B3 single or 4-beat wrap-burst cycles.
- Returns per-beat biudata_valid, biudata_error and read data to the cache.
- Handles retry, bus error, and an optional no-response watchdog.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- BURST_LEN, 4, beats per line burst; must be 4 (matches bte=01).
- TIMEOUT_CYC, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- biu_read  in  1  read request from dc FSM.
- biu_write  in  1  write request from dc FSM.
- burst  in  1  1 = line burst, 0 = single access.
- biu_addr  in  AW  request address.
- biu_sel  in  4  byte selects for a single access.
- biu_dat_i  in  DW  write data for the beat at wb_adr_o.
- biu_dat_o  out  DW  registered read data.
- biudata_valid  out  1  one-cycle pulse per completed beat.
- biudata_error  out  1  one-cycle pulse; transfer terminated.
- biu_busy  out  1  high from request acceptance until return to IDLE.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each.
- wb_sel_o  out  4.
- wb_adr_o  out  AW.
- wb_cti_o  out  3.
- wb_bte_o  out  2.
- wb_dat_o  out  DW.
- wb_dat_i  in  DW.
- wb_ack_i, wb_err_i, wb_rty_i  in  1 each.

Behaviour:
- Reset (async): state IDLE. All outputs 0; wb_cti_o = 000, wb_bte_o = 00. Asserting rst mid-burst drops cyc/stb immediately and discards the beat count.
- States: IDLE, ACTIVE, RETRY.
- IDLE:
  - Samples requests each cycle. If biu_write | biu_read, latch address, we (write wins if both asserted) and burst; clear beat counter; go to ACTIVE.
  - cyc/stb rise the cycle after acceptance (registered).
  - Burst: wb_sel_o = 4'hF, wb_cti_o = 010, wb_bte_o = 01, address bits [1:0] forced to 0.
  - Single: wb_sel_o = biu_sel, cti = 000, bte = 00.
- ACTIVE, on wb_ack_i:
  - Next cycle: biudata_valid = 1 and biu_dat_o = wb_dat_i captured at the ack.
  - Burst, not last beat: wb_adr_o[3:2] increments modulo 4 (wraps within the 16-byte line); [AW-1:4] is unchanged.
  - When the counter reaches BURST_LEN-2 (after that ack), cti becomes 111 for the final beat.
  - Last beat or single access: cyc/stb/we/sel/cti/bte go to 0 next cycle; return to IDLE; biu_busy drops in the same cycle.
- Priority when several of ack/err/rty are asserted together: err > ack > rty.
- ACTIVE, on wb_err_i:
  - Next cycle: biudata_error pulses and biudata_valid stays 0.
  - Cycle terminates and state returns to IDLE; remaining beats are dropped.
- ACTIVE, on wb_rty_i:
  - Next cycle: cyc/stb low for exactly one cycle (state RETRY).
  - Then the same beat is reissued with an unchanged address and counter; retry count is unlimited.
- Write data: wb_dat_o is combinational from biu_dat_i. Upstream presents data for the current wb_adr_o.
- Requests in ACTIVE/RETRY are ignored. Request deassertion mid-transfer does not abort it.
- A request that is still asserted in the IDLE cycle after completion starts a new transfer; upstream must drop it on its final biudata_valid.
- Bus contract: wb_adr_o/sel/we/cti/bte are stable while stb is high and no ack/err/rty has been received.

Optional Feature:
- Macro DC_BIU_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counts cycles in ACTIVE with no ack/err/rty; it clears on any of them and on entering ACTIVE.
  - On reaching TIMEOUT_CYC, the controller behaves exactly as wb_err_i: biudata_error pulse, cyc/stb drop, return to IDLE.
- Undefined: no counter logic; the controller waits indefinitely.

Test Plan:
- Burst read at biu_addr 0x0000_1008, ack every cycle:
  - Addresses go 0x1008, 0x100C, 0x1000, 0x1004.
  - cti is 010, 010, 010, 111; bte = 01; sel = F.
  - Four biudata_valid pulses carry wb_dat_i values; busy falls after the fourth.
- Single write at 0x0000_2002, biu_sel = 0011, biu_dat_i = 0xDEADBEEF, ack after 3 wait states:
  - cyc/stb/we high 4 cycles, cti = 000, wb_dat_o = 0xDEADBEEF.
  - One biudata_valid pulse.
- Burst read with wb_err_i on beat 2:
  - Two biudata_valid pulses, then one biudata_error pulse.
  - cyc low the next cycle; no further beats.
- Single read with wb_rty_i on the first attempt, then ack:
  - stb low for one cycle, then reissued at the same address.
  - Exactly one biudata_valid pulse.
- Reset asserted mid-burst (after beat 1):
  - cyc/stb/valid are 0 without a clock edge.
  - After release, a new request starts a fresh burst at beat 0.
- With DC_BIU_TIMEOUT_EN and TIMEOUT_CYC = 8, single read, slave silent:
  - biudata_error pulses after 8 idle ACTIVE cycles; cyc drops.
  - Without the macro, cyc remains high for the whole 50-cycle observation window.
